btn_debounce_pulse: RTL and testbench
=====================================

# btn_debounce_pulse

- Conditions a raw push-button input into a clean level and a single-cycle toggle pulse.
- Its `T` output drives the T input of the toggle flip-flop stage directly downstream, so each physical press toggles that stage exactly once.
- Logic: input synchronizer, debounce counter with a 4-state FSM, registered pulse generator, and a press counter for lab display.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive samples (minus one) the synchronized input must hold before a level change is accepted. Legal range is 1 to 2^`CNT_W`−1.
- `CNT_W`, default 20: width of the debounce counter.

Ports (one clock; reset is synchronous and active-low):
- `Clk` in 1: system clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset, sampled on rising edge of `Clk`.
- `btn_in` in 1: raw asynchronous button input, active-high.
- `T` out 1: registered one-cycle pulse on each accepted press (rising debounced edge).
- `btn_level` out 1: registered debounced button level.
- `busy` out 1: high while the FSM is in a WAIT state.
- `press_cnt` out 8: count of accepted presses, wraps modulo 256.

## Operation
- **Synchronizer:** `btn_in` passes through N flops to produce `btn_s`. N=2 with `DEBOUNCE_SYNC2_EN`, otherwise N=1. Reset clears all synchronizer flops to 0.
- **FSM states:** IDLE (level 0), WAIT_HI, HELD (level 1), WAIT_LO. The counter `cnt` is `CNT_W` bits.
- **IDLE:**
  - `btn_s`=1 → WAIT_HI, `cnt`←0.
  - Otherwise stay in IDLE.
- **WAIT_HI:**
  - `btn_s`=0 → IDLE, `cnt`←0 (glitch rejected).
  - Else if `cnt`==`STABLE_CYCLES`−1 → HELD, `btn_level`←1, `T`←1, `press_cnt`←`press_cnt`+1.
  - Else `cnt`←`cnt`+1.
- **HELD:**
  - `btn_s`=0 → WAIT_LO, `cnt`←0.
  - Otherwise stay in HELD.
- **WAIT_LO:**
  - `btn_s`=1 → HELD, `cnt`←0. No pulse is generated.
  - Else if `cnt`==`STABLE_CYCLES`−1 → IDLE, `btn_level`←0.
  - Else `cnt`←`cnt`+1.
- **Pulse rule:** `T` is 1 for exactly the one cycle after entry to HELD from WAIT_HI, and 0 in every other cycle. Release never pulses.
- **Counter arithmetic:**
  - `cnt` compare is unsigned. `cnt` cannot exceed `STABLE_CYCLES`−1, so it never wraps.
  - `press_cnt` wraps 255→0 silently.
- **`busy`:** equals (state==WAIT_HI || state==WAIT_LO), registered alongside the state.
- **Reset:** When `rst`=0 at a rising edge, the block takes:
  - state=IDLE, `cnt`=0, `T`=0, `btn_level`=0, `busy`=0, `press_cnt`=0, synchronizer flops=0.
  - Reset has priority over every transition, including mid-WAIT_HI and while `T` is high.

## Timing
- A new level is accepted only after `btn_s` holds for `STABLE_CYCLES`+1 consecutive FSM samples.
- Press latency (SYNC2 compiled in): `btn_in` sampled 1 at edge 0 and held → WAIT_HI at edge 2 → HELD with `T`=1 at edge 2+`STABLE_CYCLES`. `T` falls at the next edge.
- Press latency (SYNC2 compiled out): all of the above happens one edge earlier, with HELD at edge 1+`STABLE_CYCLES`.
- Release latency equals press latency. `btn_level` falls at the same relative edge, and `T` stays 0.
- Any opposite-value sample during a WAIT state restarts debounce from the stable state; no partial credit is kept.
- After reset is released with `btn_in` held high, the full press latency applies from the first sampling edge with `rst`=1.
- Maximum pulse rate: one `T` pulse per 2·(`STABLE_CYCLES`+1) cycles.

## Configuration
- `DEBOUNCE_SYNC2_EN` defined: two-flop synchronizer, `btn_s` lags `btn_in` by 2 edges. This is the required setting when `btn_in` is a real asynchronous pin.
- `DEBOUNCE_SYNC2_EN` undefined: single-flop input register, one edge less latency. Permitted only when `btn_in` is already synchronous to `Clk`.
- Both variants share identical FSM, counter and output behaviour.

## Test plan
- **Reset:** `rst`=0 for 2 cycles with `btn_in`=1 → all outputs 0 during reset. After release, `T` pulses once at edge 6 (SYNC2, `STABLE_CYCLES`=4).
- **Clean press:** `btn_in` 0→1 held 20 cycles (SYNC2) → `T`=1 for exactly one cycle after edge 6, `btn_level`=1 from edge 6, `press_cnt`=1.
- **Glitch:** `btn_in` high for 3 cycles then low → `busy` pulses, `T` never asserts, `btn_level` stays 0, `press_cnt` stays 0.
- **Release bounce:**
  - Stimulus: from HELD, drive `btn_in` 0,1,0,0… .
  - Response: WAIT_LO returns to HELD on the 1 with no `T` pulse. `btn_level` falls 4+2 edges after the final 0 begins, and `press_cnt` is unchanged.
- **Reset mid-debounce:** `rst`=0 asserted while in WAIT_HI with `cnt`=2 → next edge state=IDLE, `cnt`=0, `busy`=0, no pulse.
- **Wrap:** 256 clean presses → `press_cnt` reads 0 after press 256, and exactly 256 `T` pulses are counted.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: input synchronizer, 4-state debounce FSM, one-cycle press pulse and press counter.
// Define DEBOUNCE_SYNC2_EN for a two-flop synchronizer (asynchronous pin); otherwise a single input register is used.
module btn_debounce_pulse #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 20
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       T,
    output logic       btn_level,
    output logic       busy,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HELD    = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             t_r;
    logic             level_r;
    logic             busy_r;
    logic [7:0]       press_cnt_r;

`ifdef DEBOUNCE_SYNC2_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer for a truly asynchronous button pin
    always_ff @(posedge Clk) begin
        if (!rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn_in};
        end
    end

    assign btn_s = sync_r[1];
`else
    logic sync_r;

    // Single input register when btn_in is already synchronous to Clk
    always_ff @(posedge Clk) begin
        if (!rst) begin
            sync_r <= 1'b0;
        end else begin
            sync_r <= btn_in;
        end
    end

    assign btn_s = sync_r;
`endif

    // Debounce FSM with registered level, pulse, busy flag and press counter
    always_ff @(posedge Clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            t_r         <= 1'b0;
            level_r     <= 1'b0;
            busy_r      <= 1'b0;
            press_cnt_r <= 8'd0;
        end else begin
            t_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    level_r <= 1'b0;
                    if (btn_s) begin
                        state_r <= ST_WAIT_HI;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT_HI: begin
                    if (!btn_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_HELD;
                        level_r     <= 1'b1;
                        t_r         <= 1'b1;
                        busy_r      <= 1'b0;
                        press_cnt_r <= press_cnt_r + 8'd1;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        busy_r <= 1'b1;
                    end
                end
                ST_HELD: begin
                    level_r <= 1'b1;
                    if (!btn_s) begin
                        state_r <= ST_WAIT_LO;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT_LO: begin
                    // A bounce back high returns to HELD without a new pulse
                    if (btn_s) begin
                        state_r <= ST_HELD;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        level_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    level_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign T         = t_r;
    assign btn_level = level_r;
    assign busy      = busy_r;
    assign press_cnt = press_cnt_r;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse; latency adapts to DEBOUNCE_SYNC2_EN.
module tb_btn_debounce_pulse;

    localparam int STABLE = 4;
`ifdef DEBOUNCE_SYNC2_EN
    localparam int SYNC_N = 2;
`else
    localparam int SYNC_N = 1;
`endif
    localparam int LAT = SYNC_N + STABLE;

    logic       Clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       T;
    logic       btn_level;
    logic       busy;
    logic [7:0] press_cnt;

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;

    always #5 Clk = ~Clk;

    btn_debounce_pulse #(.STABLE_CYCLES(STABLE), .CNT_W(20)) dut (
        .Clk       (Clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .T         (T),
        .btn_level (btn_level),
        .busy      (busy),
        .press_cnt (press_cnt)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a new level, walk edge by edge through acceptance
    task automatic settle(input logic lvl, input logic pulse, input logic [7:0] cnt_exp);
        btn_in = lvl;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            check1("settle_T", T, pulse && (k == LAT));
            check1("settle_level", btn_level, (k >= LAT) ? lvl : ~lvl);
            check1("settle_busy", busy, (k >= SYNC_N) && (k < LAT));
        end
        check8("settle_press_cnt", press_cnt, cnt_exp);
        tick();
        check1("settle_T_fall", T, 1'b0);
        check1("settle_busy_after", busy, 1'b0);
        check1("settle_level_after", btn_level, lvl);
    endtask

    initial begin
        rst    = 1'b0;
        btn_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check1("rst_T", T, 1'b0);
            check1("rst_level", btn_level, 1'b0);
            check1("rst_busy", busy, 1'b0);
            check8("rst_press_cnt", press_cnt, 8'd0);
        end

        // Release reset with the button already held: full latency applies
        rst = 1'b1;
        settle(1'b1, 1'b1, 8'd1);
        settle(1'b0, 1'b0, 8'd1);

        // Clean press held for about 20 cycles
        settle(1'b1, 1'b1, 8'd2);
        for (int i = 0; i < 12; i++) begin
            tick();
            check1("hold_T", T, 1'b0);
            check1("hold_level", btn_level, 1'b1);
        end
        settle(1'b0, 1'b0, 8'd2);

        // Glitch: high for three samples only
        btn_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check1("glitch_busy", busy, (k >= SYNC_N) && (k < SYNC_N + 3));
            check1("glitch_T", T, 1'b0);
            check1("glitch_level", btn_level, 1'b0);
            if (k == 2) btn_in = 1'b0;
        end
        check8("glitch_press_cnt", press_cnt, 8'd2);

        // Release bounce 0,1,0,0...
        settle(1'b1, 1'b1, 8'd3);
        btn_in = 1'b0;
        for (int k = 0; k <= 2 + LAT; k++) begin
            tick();
            if (k == 0) btn_in = 1'b1;
            if (k == 1) btn_in = 1'b0;
            check1("bounce_T", T, 1'b0);
            check1("bounce_level", btn_level, k < 2 + LAT);
            check1("bounce_busy", busy, (k == SYNC_N) || ((k >= SYNC_N + 2) && (k < 2 + LAT)));
        end
        check8("bounce_press_cnt", press_cnt, 8'd3);

        // Reset mid WAIT_HI with cnt=2
        btn_in = 1'b1;
        for (int k = 0; k <= SYNC_N + 2; k++) tick();
        check1("mid_busy_before", busy, 1'b1);
        rst = 1'b0;
        tick();
        check1("mid_busy", busy, 1'b0);
        check1("mid_T", T, 1'b0);
        check1("mid_level", btn_level, 1'b0);
        check8("mid_press_cnt", press_cnt, 8'd0);
        rst = 1'b1;
        settle(1'b1, 1'b1, 8'd1);
        settle(1'b0, 1'b0, 8'd1);

        // Wrap: 256 presses from a fresh reset
        rst = 1'b0;
        btn_in = 1'b0;
        tick();
        rst = 1'b1;
        for (int p = 0; p < 256; p++) begin
            btn_in = 1'b1;
            for (int i = 0; i < LAT + 2; i++) begin
                tick();
                if (T === 1'b1) pulses++;
            end
            btn_in = 1'b0;
            for (int i = 0; i < LAT + 2; i++) begin
                tick();
                if (T === 1'b1) pulses++;
            end
            check8("wrap_press_cnt", press_cnt, 8'((p + 1) % 256));
        end
        tests++;
        assert (pulses == 256) else begin
            fails++;
            $error("FAIL wrap_pulses observed=%0d expected=%0d", pulses, 256);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
